// File: rtl/duck_rom_arbiter_if.sv
// duck_rom_arbiter_if: requester-side and ROM-side bus of the shared sprite ROM arbiter.
// Latency: none, wires only.
// Backpressure: req is held until gnt; the read return path never stalls.
interface duck_rom_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 12,
  parameter int DW   = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_address;
  logic [DW-1:0]      rom_q;
  logic               rd_valid;
  logic [IW-1:0]      rd_id;
  logic [DW-1:0]      rd_data;

  // Requesters plus the ROM itself
  modport master (
    output req, addr, rom_q,
    input  gnt, rom_address, rd_valid, rd_id, rd_data
  );

  // The arbiter
  modport slave (
    input  req, addr, rom_q,
    output gnt, rom_address, rd_valid, rd_id, rd_data
  );
endinterface

// File: rtl/duck_rom_arbiter.sv
// duck_rom_arbiter: round-robin sharing of one synchronous sprite ROM among NREQ requesters.
// Latency: gnt/rom_address 1 cycle after req; rd_valid/rd_id ROM_LAT cycles after the gnt cycle.
// Backpressure: req held until gnt, one read issued per cycle, return path cannot stall.
// Option: define DUCK_ARB_DISPLAY_PRIO_EN for port-0 strict priority with starvation override.
module duck_rom_arbiter #(
  parameter int NREQ       = 4,
  parameter int AW         = 12,
  parameter int DW         = 4,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_LIM = 15
) (
  input logic               vga_clk,
  input logic               reset,
  duck_rom_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] id;
  } rd_tag_t;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("duck_rom_arbiter: NREQ must be 2..8");
  end
  if (ROM_LAT < 1 || ROM_LAT > 2) begin : g_bad_lat
    $error("duck_rom_arbiter: ROM_LAT must be 1 or 2");
  end
  if (STARVE_LIM < 1) begin : g_bad_lim
    $error("duck_rom_arbiter: STARVE_LIM must be at least 1");
  end

  logic [IW-1:0] ptr;
  logic          rr_vld;
  logic [IW-1:0] rr_id;
  logic          win_vld;
  logic [IW-1:0] win_id;
  logic          adv_ptr;
  logic [IW-1:0] next_ptr;
  rd_tag_t       gnt_tag;
  rd_tag_t       pipe [ROM_LAT];
  logic [DW-1:0] rd_dat;

  // Round-robin search from ptr; walking offsets downward lets the nearest requester win last
  always_comb begin
    rr_vld = 1'b0;
    rr_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(ptr) + k) % NREQ]) begin
        rr_vld = 1'b1;
        rr_id  = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

`ifdef DUCK_ARB_DISPLAY_PRIO_EN
  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] wait_cnt [1:NREQ-1];
  logic          starve_vld;
  logic [IW-1:0] starve_id;

  // Lowest-index requesting port whose wait counter hit the limit
  always_comb begin
    starve_vld = 1'b0;
    starve_id  = '0;
    for (int i = NREQ - 1; i >= 1; i--) begin
      if (bus.req[i] && wait_cnt[i] == CW'(STARVE_LIM)) begin
        starve_vld = 1'b1;
        starve_id  = IW'(i);
      end
    end
  end

  // Starved port beats the display port, which beats round-robin
  always_comb begin
    win_vld = rr_vld;
    win_id  = rr_id;
    adv_ptr = 1'b0;
    if (starve_vld) begin
      win_id  = starve_id;
      adv_ptr = 1'b1;
    end else if (bus.req[0]) begin
      win_id  = '0;
    end else begin
      adv_ptr = rr_vld;
    end
  end

  // Wait counters: count ungranted request cycles, clear on grant, saturate at the limit
  always_ff @(posedge vga_clk) begin
    for (int i = 1; i < NREQ; i++) begin
      if (reset) begin
        wait_cnt[i] <= '0;
      end else if (win_vld && win_id == IW'(i)) begin
        wait_cnt[i] <= '0;
      end else if (bus.req[i] && wait_cnt[i] != CW'(STARVE_LIM)) begin
        wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end
`else
  assign win_vld = rr_vld;
  assign win_id  = rr_id;
  assign adv_ptr = rr_vld;
`endif

  assign next_ptr = (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;

  // Registered grant, ROM address, pointer and the return-tag shift register
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      bus.gnt         <= '0;
      bus.rom_address <= '0;
      gnt_tag         <= '0;
      ptr             <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      bus.gnt     <= '0;
      gnt_tag.vld <= win_vld;
      gnt_tag.id  <= win_id;
      if (win_vld) begin
        bus.gnt[win_id] <= 1'b1;
        bus.rom_address <= bus.addr[win_id*AW +: AW];
      end
      if (adv_ptr) begin
        ptr <= next_ptr;
      end
      // The ROM sees rom_address one cycle after the grant decision, so the tag enters here
      pipe[0] <= gnt_tag;
      for (int s = 1; s < ROM_LAT; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  assign rd_dat       = bus.rom_q;
  assign bus.rd_data  = rd_dat;
  assign bus.rd_valid = pipe[ROM_LAT-1].vld;
  assign bus.rd_id    = pipe[ROM_LAT-1].id;

endmodule

// File: tb/tb_duck_rom_arbiter.sv
// tb_duck_rom_arbiter: directed vectors against duck_rom_arbiter with a 2-cycle ROM model.
// Latency: outputs sampled 1 time unit after each vga_clk rising edge.
// Backpressure: requesters drop or change req/addr only after seeing their grant.
module tb_duck_rom_arbiter;
  localparam int NREQ       = 4;
  localparam int AW         = 12;
  localparam int DW         = 4;
  localparam int ROM_LAT    = 2;
  localparam int STARVE_LIM = 15;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_vec   = 0;
  int   n_bad   = 0;

  logic [AW-1:0] t2_addr [4] = '{12'h100, 12'h210, 12'h320, 12'h430};
  logic [DW-1:0] t2_dat  [4] = '{4'h4, 4'h6, 4'h4, 4'h2};

  logic [DW-1:0] q1;
  logic [DW-1:0] q2;

  duck_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  duck_rom_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .vga_clk(vga_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM contents: a fixed scramble of the address nibbles
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h5;
  endfunction

  // Synchronous ROM, two register stages
  always @(posedge vga_clk) begin
    q1 <= rom_fn(bus.rom_address);
    q2 <= q1;
  end
  assign bus.rom_q = q2;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    bus.addr[p*AW +: AW] = a;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.req  = '0;
    bus.addr = '0;

    // Reset state
    tick();
    check_vec("rst_gnt", 32'(bus.gnt), 32'h0);
    check_vec("rst_addr", 32'(bus.rom_address), 32'h0);
    check_vec("rst_vld", 32'(bus.rd_valid), 32'h0);
    check_vec("rst_id", 32'(bus.rd_id), 32'h0);
    tick();
    reset = 1'b0;

    // Single read from port 0
    bus.req = 4'b0001;
    set_addr(0, 12'h040);
    tick();
    check_vec("t1_gnt", 32'(bus.gnt), 32'h1);
    check_vec("t1_addr", 32'(bus.rom_address), 32'h040);
    check_vec("t1_vld0", 32'(bus.rd_valid), 32'h0);
    bus.req = '0;
    tick();
    check_vec("t1_gnt_off", 32'(bus.gnt), 32'h0);
    check_vec("t1_vld1", 32'(bus.rd_valid), 32'h0);
    tick();
    check_vec("t1_vld2", 32'(bus.rd_valid), 32'h1);
    check_vec("t1_id", 32'(bus.rd_id), 32'h0);
    check_vec("t1_dat", 32'(bus.rd_data), 32'h1);
    tick();
    check_vec("t1_vld3", 32'(bus.rd_valid), 32'h0);

    // All four ports request continuously
    do_reset();
    for (int p = 0; p < 4; p++) set_addr(p, t2_addr[p]);
    bus.req = 4'b1111;
    for (int s = 1; s <= 6; s++) begin
      tick();
      check_vec("t2_gnt", 32'(bus.gnt), 32'(1 << ((s - 1) % 4)));
      check_vec("t2_addr", 32'(bus.rom_address), 32'(t2_addr[(s - 1) % 4]));
      if (s >= 3) begin
        check_vec("t2_vld", 32'(bus.rd_valid), 32'h1);
        check_vec("t2_id", 32'(bus.rd_id), 32'((s - 3) % 4));
        check_vec("t2_dat", 32'(bus.rd_data), 32'(t2_dat[(s - 3) % 4]));
      end else begin
        check_vec("t2_vld_early", 32'(bus.rd_valid), 32'h0);
      end
    end
    bus.req = '0;
    tick();
    check_vec("t2_gnt_idle", 32'(bus.gnt), 32'h0);
    check_vec("t2_tail_id0", 32'(bus.rd_id), 32'h0);
    check_vec("t2_tail_dat0", 32'(bus.rd_data), 32'h4);
    tick();
    check_vec("t2_tail_vld1", 32'(bus.rd_valid), 32'h1);
    check_vec("t2_tail_id1", 32'(bus.rd_id), 32'h1);
    check_vec("t2_tail_dat1", 32'(bus.rd_data), 32'h6);
    tick();
    check_vec("t2_drain", 32'(bus.rd_valid), 32'h0);

    // Port 2 alone with a new address every cycle
    do_reset();
    bus.req = 4'b0100;
    set_addr(2, 12'h000);
    tick();
    check_vec("t3_gnt0", 32'(bus.gnt), 32'h4);
    check_vec("t3_addr0", 32'(bus.rom_address), 32'h000);
    set_addr(2, 12'h001);
    tick();
    check_vec("t3_gnt1", 32'(bus.gnt), 32'h4);
    check_vec("t3_addr1", 32'(bus.rom_address), 32'h001);
    set_addr(2, 12'h002);
    tick();
    check_vec("t3_gnt2", 32'(bus.gnt), 32'h4);
    check_vec("t3_addr2", 32'(bus.rom_address), 32'h002);
    check_vec("t3_vld0", 32'(bus.rd_valid), 32'h1);
    check_vec("t3_id0", 32'(bus.rd_id), 32'h2);
    check_vec("t3_dat0", 32'(bus.rd_data), 32'h5);
    bus.req = '0;
    tick();
    check_vec("t3_gnt_idle", 32'(bus.gnt), 32'h0);
    check_vec("t3_addr_hold", 32'(bus.rom_address), 32'h002);
    check_vec("t3_vld1", 32'(bus.rd_valid), 32'h1);
    check_vec("t3_dat1", 32'(bus.rd_data), 32'h4);
    tick();
    check_vec("t3_vld2", 32'(bus.rd_valid), 32'h1);
    check_vec("t3_dat2", 32'(bus.rd_data), 32'h7);
    tick();
    check_vec("t3_vld3", 32'(bus.rd_valid), 32'h0);

    // Reset right after a grant to port 1 drops the read and restarts the pointer
    do_reset();
    bus.req = 4'b0010;
    set_addr(1, 12'h556);
    set_addr(3, 12'h777);
    tick();
    check_vec("t4_gnt", 32'(bus.gnt), 32'h2);
    reset = 1'b1;
    tick();
    check_vec("t4_rst_gnt", 32'(bus.gnt), 32'h0);
    check_vec("t4_rst_addr", 32'(bus.rom_address), 32'h0);
    check_vec("t4_rst_vld", 32'(bus.rd_valid), 32'h0);
    check_vec("t4_rst_id", 32'(bus.rd_id), 32'h0);
    reset   = 1'b0;
    bus.req = 4'b1010;
    tick();
    check_vec("t4_ptr0_gnt", 32'(bus.gnt), 32'h2);
    check_vec("t4_dropped", 32'(bus.rd_valid), 32'h0);
    bus.req = '0;
    tick();
    check_vec("t4_vld_gap", 32'(bus.rd_valid), 32'h0);
    tick();
    check_vec("t4_vld", 32'(bus.rd_valid), 32'h1);
    check_vec("t4_id", 32'(bus.rd_id), 32'h1);
    check_vec("t4_dat", 32'(bus.rd_data), 32'h3);

    // Ports 0 and 3 request continuously
    do_reset();
    set_addr(0, 12'h010);
    set_addr(3, 12'h020);
    bus.req = 4'b1001;
`ifdef DUCK_ARB_DISPLAY_PRIO_EN
    for (int s = 1; s <= 17; s++) begin
      tick();
      check_vec("t5_prio_gnt", 32'(bus.gnt), (s == 16) ? 32'h8 : 32'h1);
    end
`else
    for (int s = 1; s <= 6; s++) begin
      tick();
      check_vec("t5_rr_gnt", 32'(bus.gnt), (s % 2 == 1) ? 32'h1 : 32'h8);
    end
`endif
    bus.req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/duck_rom_arbiter.md
# duck_rom_arbiter

Round-robin arbiter sharing one synchronous sprite ROM (64x64 sprite, 4-bit palette index per pixel, 12-bit address) among NREQ requesters: the VGA pixel renderer, hit-box/collision sampler, and other sprite consumers. It sits between the requesters and the ROM. It accepts one read per cycle, tracks each read through the fixed ROM latency, and returns the data tagged with the requester ID. Port 0 is the display port.

## Interface
- NREQ, 4: number of requesters, 2..8.
- AW, 12: ROM address width.
- DW, 4: ROM data width (palette index).
- ROM_LAT, 1: ROM read latency in vga_clk cycles, 1 or 2.
- STARVE_LIM, 15: wait-cycle limit for starvation override (used only with the macro).
- vga_clk  in  1  sole clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-port read request; level, held until granted.
- addr  in  NREQ*AW  per-port address; port i at bits [i*AW +: AW]; stable while req high.
- gnt  out  NREQ  one-hot registered grant pulse; at most one bit set.
- rom_address  out  AW  registered address to ROM.
- rom_q  in  DW  ROM data, valid ROM_LAT cycles after rom_address.
- rd_valid  out  1  rd_data/rd_id valid this cycle.
- rd_id  out  $clog2(NREQ)  requester that owns rd_data.
- rd_data  out  DW  rom_q passed through, qualified by rd_valid.

## Operation
- Each posedge picks the winner among asserted req bits.
  - Search starts at port ptr and wraps modulo NREQ.
  - The winner i gets gnt[i]=1 and rom_address=addr[i], both registered.
  - Then ptr <= (i+1) mod NREQ.
- No req asserted: gnt=0, rom_address holds its value, ptr unchanged, a zero-valid entry enters the pipeline.
- A requester keeps req/addr until it sees gnt[i]. On the grant cycle it may present a new addr with req still high, giving back-to-back grants when it is alone. A port with req low on a grant edge is never granted.
- The return pipeline is a ROM_LAT-deep shift register of {valid, id}. Its output drives rd_valid/rd_id. rd_data = rom_q combinationally; it is don't-care while rd_valid=0.
- Throughput is one read per cycle. Reads return in issue order.
- Reset values:
  - gnt=0, rom_address=0, rd_valid=0, rd_id=0, ptr=0.
  - Pipeline cleared.
  - Starvation counters 0.
- Reset mid-operation drops in-flight reads: no rd_valid follows for them.

## Timing
- req[i] high before edge k and winning -> gnt[i] and rom_address valid in cycle k..k+1. Grant latency is 1 cycle.
- rd_valid with rd_id=i is high exactly ROM_LAT cycles after the gnt[i] cycle.
- Worst-case grant wait is NREQ-1 cycles for a continuously requesting port in round-robin mode.
- reset and req in the same cycle: reset wins, no grant next cycle.

## Configuration
- DUCK_ARB_DISPLAY_PRIO_EN defined: port 0 has strict priority over round-robin.
  - Each other port i keeps a wait counter: increments while req[i] high and not granted, clears on gnt[i], saturates at STARVE_LIM.
  - Any port whose counter reaches STARVE_LIM is granted ahead of port 0 for one cycle. If several ports qualify, the lowest index wins.
  - ptr advances only on non-port-0 grants.
- Undefined: pure round-robin across all ports; no counters are synthesized.

## Test plan
- Reset, then req=4'b0001, addr0=12'h040 -> gnt=0001 next cycle, rom_address=12'h040, rd_valid=1 with rd_id=0 after ROM_LAT cycles, rd_data=ROM[0x040].
- All four ports request continuously with distinct addresses from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001; rd_id sequence 0,1,2,3 delayed by ROM_LAT.
- Only port 2 requests with addr changing every cycle (0x000,0x001,0x002) -> gnt[2] three consecutive cycles, three rd_valid cycles in order with matching data.
- Grant to port 1 issued, then reset on the next edge (ROM_LAT=2) -> no rd_valid for that read; all outputs 0; next grant starts search at port 0.
- With DUCK_ARB_DISPLAY_PRIO_EN, STARVE_LIM=15: port 0 and port 3 request continuously -> port 0 granted 15 cycles, then port 3 once, then port 0 resumes; without the macro they alternate every cycle.
